// File: rtl/triangle_raster_scan.sv
// triangle_raster_scan
//   Upstream driver for a point-in-triangle tester. A triangle is latched on
//   start, its bounding box is computed, and every pixel in the box is offered
//   to the tester in row-major order over a req/done handshake. Pixels the
//   tester reports as inside leave on a ready/valid stream, and they are
//   counted per triangle.
//
//   Optional build macro: CLIP_EN -- clamps the bounding box to the screen
//   (SCREEN_W x SCREEN_H). A box that lies entirely off screen issues no
//   candidates.
//
// Ports
//   clk, rst              clock (rising edge) / asynchronous active-high reset
//   start                 1-cycle pulse, accepted only in IDLE
//   p1x..p3y              vertices, sampled on the accepted start cycle
//   t_p1x..t_p3y          latched vertices, stable to the tester during the scan
//   ptx, pty, t_req       candidate point and request to the tester
//   t_done, t_inside      tester result strobe and verdict
//   pix_valid, pix_ready  inside-pixel stream handshake
//   pix_x, pix_y          inside-pixel coordinates
//   busy, done            scan in progress / 1-cycle end-of-triangle pulse
//   inside_cnt            inside pixels emitted (saturating)
module triangle_raster_scan #(
  parameter int COORD_W  = 11,
  parameter int CNT_W    = 22,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] p1x,
  input  logic [COORD_W-1:0] p1y,
  input  logic [COORD_W-1:0] p2x,
  input  logic [COORD_W-1:0] p2y,
  input  logic [COORD_W-1:0] p3x,
  input  logic [COORD_W-1:0] p3y,
  output logic [COORD_W-1:0] t_p1x,
  output logic [COORD_W-1:0] t_p1y,
  output logic [COORD_W-1:0] t_p2x,
  output logic [COORD_W-1:0] t_p2y,
  output logic [COORD_W-1:0] t_p3x,
  output logic [COORD_W-1:0] t_p3y,
  output logic [COORD_W-1:0] ptx,
  output logic [COORD_W-1:0] pty,
  output logic               t_req,
  input  logic               t_done,
  input  logic               t_inside,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   inside_cnt
);

  // Screen size must describe at least one pixel; checked at elaboration.
  if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
    $error("triangle_raster_scan: SCREEN_W/SCREEN_H must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_ISSUE, S_WAIT, S_EMIT, S_NEXT, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] xmin, xmax, ymax;
  logic [COORD_W-1:0] x, y;

  // Bounding box of the latched vertices, only consumed in BBOX.
  logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
  logic [COORD_W-1:0] bx_max_c, by_max_c;
  logic               off_screen;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    bx_min = min3(t_p1x, t_p2x, t_p3x);
    bx_max = max3(t_p1x, t_p2x, t_p3x);
    by_min = min3(t_p1y, t_p2y, t_p3y);
    by_max = max3(t_p1y, t_p2y, t_p3y);
`ifdef CLIP_EN
    bx_max_c   = (bx_max > COORD_W'(SCREEN_W - 1)) ? COORD_W'(SCREEN_W - 1) : bx_max;
    by_max_c   = (by_max > COORD_W'(SCREEN_H - 1)) ? COORD_W'(SCREEN_H - 1) : by_max;
    off_screen = (bx_min > COORD_W'(SCREEN_W - 1)) || (by_min > COORD_W'(SCREEN_H - 1));
`else
    bx_max_c   = bx_max;
    by_max_c   = by_max;
    off_screen = 1'b0;
`endif
  end

  // Equality compares only: stepping never goes past xmax/ymax, so a box
  // reaching the top of the coordinate range cannot wrap.
  logic at_xmax, at_end;
  assign at_xmax = (x == xmax);
  assign at_end  = at_xmax && (y == ymax);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BBOX;
      S_BBOX:  state_nxt = off_screen ? S_FIN : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (t_done) state_nxt = t_inside ? S_EMIT : S_NEXT;
      S_EMIT:  if (pix_ready) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = at_end ? S_FIN : S_ISSUE;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    t_req     = 1'b0;
    pix_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_BBOX, S_ISSUE, S_NEXT: busy = 1'b1;
      S_WAIT: begin
        busy  = 1'b1;
        t_req = 1'b1;
      end
      S_EMIT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign pix_x = x;
  assign pix_y = y;

  // Datapath: vertex latch, box, scan position, candidate, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_p1x      <= '0;
      t_p1y      <= '0;
      t_p2x      <= '0;
      t_p2y      <= '0;
      t_p3x      <= '0;
      t_p3y      <= '0;
      xmin       <= '0;
      xmax       <= '0;
      ymax       <= '0;
      x          <= '0;
      y          <= '0;
      ptx        <= '0;
      pty        <= '0;
      inside_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          t_p1x      <= p1x;
          t_p1y      <= p1y;
          t_p2x      <= p2x;
          t_p2y      <= p2y;
          t_p3x      <= p3x;
          t_p3y      <= p3y;
          inside_cnt <= '0;
        end
        S_BBOX: begin
          xmin <= bx_min;
          xmax <= bx_max_c;
          ymax <= by_max_c;
          x    <= bx_min;
          y    <= by_min;
        end
        S_ISSUE: begin
          ptx <= x;
          pty <= y;
        end
        S_EMIT: if (pix_ready && (inside_cnt != '1)) inside_cnt <= inside_cnt + 1'b1;
        S_NEXT: if (!at_end) begin
          if (at_xmax) begin
            x <= xmin;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_raster_scan.sv
module tb_triangle_raster_scan;
  localparam int CW = 11;
  localparam int NW = 22;

  logic          clk = 0, rst = 1, start = 0;
  logic [CW-1:0] p1x = 0, p1y = 0, p2x = 0, p2y = 0, p3x = 0, p3y = 0;
  logic [CW-1:0] t_p1x, t_p1y, t_p2x, t_p2y, t_p3x, t_p3y, ptx, pty, pix_x, pix_y;
  logic          t_req, t_done = 0, t_inside = 0, pix_valid, pix_ready = 1, busy, done;
  logic [NW-1:0] inside_cnt;

  triangle_raster_scan #(.COORD_W(CW), .CNT_W(NW), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .t_p1x(t_p1x), .t_p1y(t_p1y), .t_p2x(t_p2x), .t_p2y(t_p2y), .t_p3x(t_p3x), .t_p3y(t_p3y),
    .ptx(ptx), .pty(pty), .t_req(t_req), .t_done(t_done), .t_inside(t_inside),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done), .inside_cnt(inside_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int ax, ay, bx, by, cx, cy;
    bit stall;    // hold pix_ready low 3 cycles on the 2nd pixel
    bit restart;  // pulse start (other vertices) mid-scan
    int exp_req;
    int exp_cnt;
  } vec_t;

`ifdef CLIP_EN
  localparam int NV = 9;
`else
  localparam int NV = 7;
`endif
  vec_t vecs[NV];

  // Bench-side copy of the current triangle (tester model and scan model)
  int cur_ax, cur_ay, cur_bx, cur_by, cur_cx, cur_cy;
  int req_q[$], pix_q[$];
  int done_n;
  bit stall_en;
  int pix_n, stall_k;
  int tcnt = 0;

  function automatic int edgef(int ax, int ay, int bx, int by, int px, int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic bit in_tri(int px, int py);
    int e0, e1, e2;
    e0 = edgef(cur_ax, cur_ay, cur_bx, cur_by, px, py);
    e1 = edgef(cur_bx, cur_by, cur_cx, cur_cy, px, py);
    e2 = edgef(cur_cx, cur_cy, cur_ax, cur_ay, px, py);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  // Tester model: t_done one cycle, 4 cycles after t_req rises; inside incl. edges
  int hold_x, hold_y;
  always @(negedge clk) begin
    if (t_done) begin
      t_done = 0;
      tcnt   = 0;
    end else if (t_req) begin
      if (tcnt == 0) begin
        req_q.push_back(ptx * 65536 + pty);
        hold_x = ptx;
        hold_y = pty;
      end
      tcnt++;
      if (tcnt == 4) begin
        chk("pt_hold", {ptx, 5'b0, pty}, {hold_x[CW-1:0], 5'b0, hold_y[CW-1:0]});
        t_inside = in_tri(ptx, pty);
        t_done   = 1;
      end
    end else begin
      tcnt = 0;
    end
  end

  // Pixel sink: optional 3-cycle stall on the 2nd pixel
  always @(negedge clk) begin
    if (done) done_n++;
    if (pix_valid && !rst) begin
      if (stall_en && pix_n == 1 && stall_k < 3) begin
        pix_ready = 0;
        stall_k++;
        chk("stall_pix_x", pix_x, 1);
        chk("stall_pix_y", pix_y, 0);
        chk("stall_no_req", t_req, 0);
      end else begin
        pix_ready = 1;
        pix_q.push_back(pix_x * 65536 + pix_y);
        pix_n++;
      end
    end else begin
      pix_ready = 1;
    end
  end

  task automatic run_vec(input vec_t v);
    int exp_req_q[$], exp_pix_q[$];
    int xmn, xmx, ymn, ymx, cyc;
    bit ok;
    cur_ax = v.ax; cur_ay = v.ay; cur_bx = v.bx; cur_by = v.by; cur_cx = v.cx; cur_cy = v.cy;
    req_q.delete(); pix_q.delete();
    done_n = 0; pix_n = 0; stall_k = 0; stall_en = v.stall;
    // Row-major scan model
    xmn = (v.ax < v.bx) ? v.ax : v.bx; xmn = (xmn < v.cx) ? xmn : v.cx;
    xmx = (v.ax > v.bx) ? v.ax : v.bx; xmx = (xmx > v.cx) ? xmx : v.cx;
    ymn = (v.ay < v.by) ? v.ay : v.by; ymn = (ymn < v.cy) ? ymn : v.cy;
    ymx = (v.ay > v.by) ? v.ay : v.by; ymx = (ymx > v.cy) ? ymx : v.cy;
`ifdef CLIP_EN
    if (xmx > 639) xmx = 639;
    if (ymx > 479) ymx = 479;
`endif
    for (int yy = ymn; yy <= ymx; yy++)
      for (int xx = xmn; xx <= xmx; xx++) begin
        exp_req_q.push_back(xx * 65536 + yy);
        if (in_tri(xx, yy)) exp_pix_q.push_back(xx * 65536 + yy);
      end

    @(negedge clk);
    p1x = CW'(v.ax); p1y = CW'(v.ay); p2x = CW'(v.bx); p2y = CW'(v.by); p3x = CW'(v.cx); p3y = CW'(v.cy);
    start = 1;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (v.restart && cyc == 20) begin
        p1x = 5; p1y = 5; p2x = 5; p2y = 5; p3x = 5; p3y = 5;
        start = 1;
      end
      if (cyc == 1) chk({v.name, "_busy"}, busy, 1);
      if (done) break;
    end
    chk({v.name, "_done_seen"}, (cyc < 3000), 1);
    if (v.exp_req == 0) chk({v.name, "_done_fast"}, (cyc <= 3), 1);
    repeat (4) @(negedge clk);
    chk({v.name, "_done_n"}, done_n, 1);
    chk({v.name, "_busy_end"}, busy, 0);
    chk({v.name, "_req_n"}, req_q.size(), v.exp_req);
    chk({v.name, "_pix_n"}, pix_q.size(), v.exp_cnt);
    chk({v.name, "_cnt"}, inside_cnt, v.exp_cnt);
    chk({v.name, "_lat_p1x"}, t_p1x, v.ax);
    chk({v.name, "_lat_p3y"}, t_p3y, v.cy);
    ok = (req_q.size() == exp_req_q.size());
    foreach (req_q[i]) if (ok && req_q[i] != exp_req_q[i]) ok = 0;
    chk({v.name, "_req_order"}, ok, 1);
    ok = (pix_q.size() == exp_pix_q.size());
    foreach (pix_q[i]) if (ok && pix_q[i] != exp_pix_q[i]) ok = 0;
    chk({v.name, "_pix_order"}, ok, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tp"}, {t_p1x, t_p1y, t_p2x} | {11'd0, t_p2y, t_p3x, t_p3y} , 0);
    chk({tag, "_pt"}, {ptx, pty}, 0);
    chk({tag, "_pix"}, {pix_x, pix_y}, 0);
    chk({tag, "_ctl"}, {t_req, pix_valid, busy, done}, 0);
    chk({tag, "_cnt"}, inside_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{"t1",      0, 0, 4, 0, 0, 4, 0, 0, 25, 15};
    vecs[1] = '{"t2",      5, 5, 5, 5, 5, 5, 0, 0, 1, 1};
    vecs[2] = '{"t3",      0, 0, 4, 0, 0, 4, 1, 0, 25, 15};
    vecs[3] = '{"t4",      0, 0, 4, 0, 0, 4, 0, 1, 25, 15};
    vecs[4] = '{"line",    2, 1, 6, 1, 2, 1, 0, 0, 5, 5};
    vecs[5] = '{"small",   1, 1, 3, 1, 1, 3, 0, 0, 9, 6};
`ifdef CLIP_EN
    vecs[6] = '{"top",     2045, 0, 2047, 0, 2047, 2, 0, 0, 0, 0};
    vecs[7] = '{"t5",      630, 470, 700, 470, 630, 520, 0, 0, 100, 100};
    vecs[8] = '{"t6",      700, 500, 700, 500, 700, 500, 0, 0, 0, 0};
`else
    vecs[6] = '{"top",     2045, 0, 2047, 0, 2047, 2, 0, 0, 9, 6};
`endif

    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // start during FIN is ignored
    cur_ax = 0; cur_ay = 0; cur_bx = 4; cur_by = 0; cur_cx = 0; cur_cy = 4;
    req_q.delete(); pix_q.delete(); done_n = 0; pix_n = 0; stall_en = 0;
    @(negedge clk);
    p1x = 0; p1y = 0; p2x = 4; p2y = 0; p3x = 0; p3y = 4;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 3000 && !done; c++) @(negedge clk);
    chk("fin_done", done, 1);
    start = 1;          // sampled while in FIN
    @(negedge clk);
    start = 0;
    req_q.delete();
    repeat (10) @(negedge clk);
    chk("fin_start_busy", busy, 0);
    chk("fin_start_req", req_q.size(), 0);
    chk("fin_start_cnt", inside_cnt, 15);

    // reset mid-scan
    done_n = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (30) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    rst = 0;
    done_n = 0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", done_n, 0);
    chk("mid_idle", {busy, t_req, pix_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
